hash_enc_sched: RTL and testbench
=================================

HASH_ENC_SCHED -- requirements
Module: hash_enc_sched

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 32, giving the coordinate, resolution and hash-index width.
REQ-002 The block SHALL have parameter NUM_LEVELS, default 16, giving the number of resolution levels per point; legal range 2..64.
REQ-003 The block SHALL have parameter ENG_LATENCY, default 6, giving the cycles from engine enable to a valid engine result; legal minimum 1.
REQ-004 The block SHALL have parameter LVL_W = $clog2(NUM_LEVELS), derived.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- pt_valid  in  1  input point valid.
- pt_ready  out  1  scheduler accepts a point.
- pt_x, pt_y, pt_z  in  DATA_SIZE each  point coordinates.
- cfg_we  in  1  resolution-table write strobe.
- cfg_level  in  LVL_W  table entry to write.
- cfg_res  in  DATA_SIZE  resolution value for that level.
- cfg_drop  out  1  one-cycle pulse when a write is discarded.
- eng_en  out  1  one-cycle start pulse to the hash-index engine.
- eng_x, eng_y, eng_z  out  DATA_SIZE each  coordinates to the engine.
- eng_res  out  DATA_SIZE  resolution to the engine, replicated to all three axes outside the block.
- eng_hash_idx  in  8*DATA_SIZE  the engine's 8 corner indices; corner k is in bits [k*DATA_SIZE +: DATA_SIZE].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_level  out  LVL_W  level of the current result.
- out_pt_id  out  8  sequence number of the point.
- out_last  out  1  result is for level NUM_LEVELS-1.
- out_hash_idx  out  8*DATA_SIZE  captured corner indices.
- busy  out  1  state is not IDLE.

Function
REQ-006 The block SHALL hold a NUM_LEVELS x DATA_SIZE resolution table, reset to all zeros.
REQ-007 The FSM SHALL have the states IDLE, ISSUE, WAIT and OUT.
REQ-008 pt_ready SHALL equal 1 only in IDLE; busy SHALL equal (state != IDLE).
REQ-009 IDLE: when pt_valid & pt_ready, the block SHALL latch pt_x/y/z, set the level counter to 0 and go to ISSUE.
REQ-010 ISSUE: for exactly one cycle, eng_en = 1 and eng_res = table[level]; next state is WAIT with the wait counter set to ENG_LATENCY-1.
REQ-011 eng_x/y/z SHALL present the latched point from ISSUE until the point completes.
REQ-012 WAIT: the wait counter SHALL decrement each cycle. In the cycle it reads 0, the block SHALL register eng_hash_idx into out_hash_idx and go to OUT. The sample is therefore taken exactly ENG_LATENCY cycles after the eng_en cycle.
REQ-013 OUT: out_valid = 1, and out_hash_idx, out_level, out_pt_id and out_last SHALL stay stable until out_valid & out_ready.
REQ-014 On the OUT handshake with level < NUM_LEVELS-1, the level SHALL increment and the state SHALL go to ISSUE.
REQ-015 On the OUT handshake with level = NUM_LEVELS-1, the state SHALL go to IDLE and pt_id SHALL increment modulo 256 (255 wraps to 0).
REQ-016 eng_en SHALL never assert outside ISSUE, so at most one engine operation is outstanding at a time.
REQ-017 A cfg_we while in IDLE SHALL write table[cfg_level] on that edge.
REQ-018 A cfg_we while busy SHALL leave the table unchanged and pulse cfg_drop for one cycle.
REQ-019 If a cfg_we in IDLE coincides with a point handshake, the write SHALL complete first, so ISSUE for level 0 uses the new value.
REQ-020 The minimum time per level SHALL be ENG_LATENCY+2 cycles (ISSUE + WAIT + OUT); with out_ready held high a point SHALL take NUM_LEVELS*(ENG_LATENCY+2) cycles.
REQ-021 out_valid SHALL not depend combinationally on out_ready, and pt_ready SHALL not depend combinationally on pt_valid.

Reset
REQ-022 While rst = 1, asynchronously: state = IDLE; level, wait counter and pt_id = 0; resolution table = 0; eng_en, out_valid, cfg_drop = 0; eng_x/y/z, eng_res, out_hash_idx, out_level, out_last = 0.
REQ-023 Reset asserted mid-point SHALL abandon the point without emitting further results. After release, pt_ready = 1 in the first cycle, and any engine result arriving later SHALL be ignored.

Verification
REQ-024 Program table[L] = 16<<L for L = 0..15. Send point (1,2,3) with out_ready = 1. Required:
- eng_en pulses 16 times, 8 cycles apart.
- eng_res = 16, 32, ..., 524288.
- out_level = 0..15, with out_last = 1 only on level 15.
- the first out_valid appears 8 cycles after the point handshake.
- pt_ready returns the cycle after the 16th handshake.
REQ-025 Drive an engine model with a distinct eng_hash_idx value per cycle. Required: out_hash_idx equals the value present exactly 6 cycles after each eng_en.
REQ-026 Hold out_ready = 0 for 20 cycles in the first OUT. Required: outputs stay stable, no eng_en pulse occurs, and the level-1 ISSUE follows 1 cycle after out_ready rises.
REQ-027 Assert cfg_we while busy. Required: cfg_drop pulses and the table readback (via eng_res on the next point) is unchanged. Assert cfg_we in IDLE together with a point handshake. Required: level 0 eng_res uses the new value.
REQ-028 Send 257 points. Required: out_pt_id goes 0..255, then 0.
REQ-029 Assert rst in WAIT of level 5. Required: all outputs are 0 immediately, pt_ready = 1 after release, the table is cleared, and the next point starts at level 0 with pt_id 0.

Source files
------------

// File: rtl/hash_enc_sched.sv
// Per-point level scheduler for a multi-resolution hash encoder.
// It walks NUM_LEVELS levels per point and issues one engine op per level, with a fixed engine latency.
module hash_enc_sched #(
    parameter int DATA_SIZE   = 32,
    parameter int NUM_LEVELS  = 16,
    parameter int ENG_LATENCY = 6,
    parameter int LVL_W       = $clog2(NUM_LEVELS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pt_valid,
    output logic                   pt_ready,
    input  logic [DATA_SIZE-1:0]   pt_x,
    input  logic [DATA_SIZE-1:0]   pt_y,
    input  logic [DATA_SIZE-1:0]   pt_z,
    input  logic                   cfg_we,
    input  logic [LVL_W-1:0]       cfg_level,
    input  logic [DATA_SIZE-1:0]   cfg_res,
    output logic                   cfg_drop,
    output logic                   eng_en,
    output logic [DATA_SIZE-1:0]   eng_x,
    output logic [DATA_SIZE-1:0]   eng_y,
    output logic [DATA_SIZE-1:0]   eng_z,
    output logic [DATA_SIZE-1:0]   eng_res,
    input  logic [8*DATA_SIZE-1:0] eng_hash_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LVL_W-1:0]       out_level,
    output logic [7:0]             out_pt_id,
    output logic                   out_last,
    output logic [8*DATA_SIZE-1:0] out_hash_idx,
    output logic                   busy
);

    localparam int WCW = (ENG_LATENCY > 1) ? $clog2(ENG_LATENCY) : 1;
    localparam logic [LVL_W-1:0] LAST_LVL  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [WCW-1:0]   WAIT_INIT = WCW'(ENG_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t                               state, state_nxt;
    logic [NUM_LEVELS-1:0][DATA_SIZE-1:0] res_tbl;
    logic [LVL_W-1:0]                     level;
    logic [WCW-1:0]                       wait_cnt;
    logic [7:0]                           pt_id;
    logic                                 lvl_last;

    assign lvl_last = (level == LAST_LVL);

    always_comb begin
        state_nxt = state;
        pt_ready  = 1'b0;
        eng_en    = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                pt_ready = 1'b1;
                if (pt_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                eng_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (wait_cnt == '0) state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = lvl_last ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    // Table is read directly so a write landing on the accept edge is seen by ISSUE.
    assign eng_res   = busy ? res_tbl[level] : '0;
    assign out_level = level;
    assign out_pt_id = pt_id;
    assign out_last  = out_valid && lvl_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            res_tbl      <= '0;
            level        <= '0;
            wait_cnt     <= '0;
            pt_id        <= '0;
            cfg_drop     <= 1'b0;
            eng_x        <= '0;
            eng_y        <= '0;
            eng_z        <= '0;
            out_hash_idx <= '0;
        end else begin
            state    <= state_nxt;
            cfg_drop <= cfg_we && (state != IDLE);
            if (cfg_we && (state == IDLE) && (32'(cfg_level) < NUM_LEVELS))
                res_tbl[cfg_level] <= cfg_res;
            case (state)
                IDLE: if (pt_valid) begin
                    eng_x <= pt_x;
                    eng_y <= pt_y;
                    eng_z <= pt_z;
                    level <= '0;
                end
                ISSUE: wait_cnt <= WAIT_INIT;
                WAIT: begin
                    if (wait_cnt == '0) out_hash_idx <= eng_hash_idx;
                    else                wait_cnt     <= wait_cnt - 1'b1;
                end
                OUT: if (out_ready) begin
                    if (lvl_last) pt_id <= pt_id + 8'd1;
                    else          level <= level + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_enc_sched.sv
// Directed bench for hash_enc_sched: level sequencing, engine sample timing, stall,
// config drop, mid-point reset and pt_id wrap.
module tb_hash_enc_sched;

    localparam int DS = 32;
    localparam int NL = 16;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pt_valid, pt_ready;
    logic [DS-1:0]   pt_x, pt_y, pt_z;
    logic            cfg_we;
    logic [LW-1:0]   cfg_level;
    logic [DS-1:0]   cfg_res;
    logic            cfg_drop, eng_en;
    logic [DS-1:0]   eng_x, eng_y, eng_z, eng_res;
    logic [8*DS-1:0] eng_hash_idx, out_hash_idx;
    logic            out_valid, out_ready, out_last, busy;
    logic [LW-1:0]   out_level;
    logic [7:0]      out_pt_id;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    hash_enc_sched dut (
        .clk(clk), .rst(rst),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_z(pt_z),
        .cfg_we(cfg_we), .cfg_level(cfg_level), .cfg_res(cfg_res), .cfg_drop(cfg_drop),
        .eng_en(eng_en), .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z), .eng_res(eng_res),
        .eng_hash_idx(eng_hash_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level),
        .out_pt_id(out_pt_id), .out_last(out_last), .out_hash_idx(out_hash_idx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine model: a distinct index set every cycle, keyed on the cycle count.
    function automatic logic [8*DS-1:0] hidx(input int c);
        logic [8*DS-1:0] r;
        for (int k = 0; k < 8; k++) r[k*DS +: DS] = DS'((c << 4) | k);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    assign eng_hash_idx = hidx(cyc);

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_point(input int x, input int y, input int z);
        pt_valid = 1'b1; pt_x = DS'(x); pt_y = DS'(y); pt_z = DS'(z);
        @(negedge clk);
        pt_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    task automatic run_point(input int v, input int exp_id);
        int  got_id;
        bit  seen;
        got_id = -1;
        seen   = 0;
        send_point(v, v, v);
        for (int i = 0; i < 300 && busy; i++) begin
            if (out_valid && !seen) begin seen = 1; got_id = int'(out_pt_id); end
            @(negedge clk);
        end
        chk("pt_done", busy, 0);
        chk("pt_id", got_id, exp_id);
    endtask

    initial begin
        int n_en, n_out, c_en, n;
        bit stable, en_seen, ov;
        logic [8*DS-1:0] h0;

        rst = 1'b1; pt_valid = 0; pt_x = 0; pt_y = 0; pt_z = 0;
        cfg_we = 0; cfg_level = 0; cfg_res = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_pt_ready", pt_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_eng_en", eng_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_eng_res", eng_res, 0);
        chk("rst_hash", out_hash_idx, 0);
        chk("rst_level", out_level, 0);
        chk("rst_pt_id", out_pt_id, 0);
        rst = 1'b0;
        @(negedge clk);

        // table[L] = 16<<L
        for (int l = 0; l < NL; l++) begin
            cfg_we = 1; cfg_level = LW'(l); cfg_res = DS'(16 << l);
            @(negedge clk);
            cfg_we = 0;
            chk("cfg_idle_nodrop", cfg_drop, 0);
        end

        // full point with out_ready high
        out_ready = 1;
        chk("t1_ready", pt_ready, 1);
        send_point(1, 2, 3);
        n_en = 0; n_out = 0; c_en = 0;
        for (int t = 1; t <= 140; t++) begin
            if (eng_en) begin
                chk("t1_res", eng_res, 16 << n_en);
                chk("t1_en_time", t, 1 + 8 * n_en);
                c_en = cyc;
                n_en++;
            end
            if (out_valid) begin
                chk("t1_level", out_level, n_out);
                chk("t1_last", out_last, (n_out == NL - 1));
                chk("t1_hash", out_hash_idx, hidx(c_en + 6));
                chk("t1_ov_time", t, 8 + 8 * n_out);
                chk("t1_eng_xyz", {eng_x, eng_y, eng_z}, {32'd1, 32'd2, 32'd3});
                chk("t1_id", out_pt_id, 0);
                n_out++;
            end
            if (t == 128) chk("t1_not_ready", pt_ready, 0);
            if (t == 129) chk("t1_ready_back", pt_ready, 1);
            @(negedge clk);
        end
        chk("t1_n_en", n_en, 16);
        chk("t1_n_out", n_out, 16);

        // stall the first OUT for 20 cycles
        out_ready = 0;
        send_point(4, 5, 6);
        chk("t2_en", eng_en, 1);
        c_en = cyc;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("t2_ov", out_valid, 1);
        chk("t2_hash", out_hash_idx, hidx(c_en + 6));
        chk("t2_id", out_pt_id, 1);
        h0 = out_hash_idx;
        stable = 1; en_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_hash_idx !== h0 || out_level !== 0 || out_pt_id !== 1 ||
                out_valid !== 1 || out_last !== 0) stable = 0;
            if (eng_en) en_seen = 1;
        end
        chk("t2_stable", stable, 1);
        chk("t2_no_en", en_seen, 0);
        out_ready = 1;
        @(negedge clk);
        chk("t2_issue1", eng_en, 1);
        chk("t2_res1", eng_res, 32);
        chk("t2_ov_drop", out_valid, 0);
        wait_idle("t2_done");

        // config write while busy is dropped
        send_point(7, 7, 7);
        cfg_we = 1; cfg_level = 0; cfg_res = 999;
        @(negedge clk);
        cfg_we = 0;
        chk("t3_drop", cfg_drop, 1);
        @(negedge clk);
        chk("t3_drop_end", cfg_drop, 0);
        wait_idle("t3_done");
        send_point(1, 1, 1);
        chk("t3_kept_en", eng_en, 1);
        chk("t3_kept", eng_res, 16);
        wait_idle("t3_done2");
        // write coinciding with the accept edge
        cfg_we = 1; cfg_level = 0; cfg_res = 777;
        send_point(2, 2, 2);
        cfg_we = 0;
        chk("t3_new_en", eng_en, 1);
        chk("t3_new_res", eng_res, 777);
        chk("t3_no_drop", cfg_drop, 0);
        wait_idle("t3_done3");

        // reset during the WAIT of level 5
        send_point(9, 9, 9);
        n = 0;
        for (int i = 0; i < 100 && n < 6; i++) begin
            if (eng_en) n++;
            if (n < 6) @(negedge clk);
        end
        chk("t4_reach_l5", n, 6);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t4_busy", busy, 0);
        chk("t4_eng_en", eng_en, 0);
        chk("t4_out_valid", out_valid, 0);
        chk("t4_cfg_drop", cfg_drop, 0);
        chk("t4_eng_x", eng_x, 0);
        chk("t4_eng_res", eng_res, 0);
        chk("t4_hash", out_hash_idx, 0);
        chk("t4_level", out_level, 0);
        chk("t4_last", out_last, 0);
        chk("t4_pt_id", out_pt_id, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t4_ready", pt_ready, 1);
        ov = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || eng_en) ov = 1;
        end
        chk("t4_quiet", ov, 0);
        send_point(2, 3, 4);
        chk("t4_tbl_clr", eng_res, 0);
        chk("t4_lvl0", out_level, 0);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk("t4_ov", out_valid, 1);
        chk("t4_id0", out_pt_id, 0);
        wait_idle("t4_done");

        // pt_id runs 1..255 then wraps to 0
        for (int i = 1; i <= 256; i++) run_point(i, i % 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
